// File: rtl/mask_pattern_feeder.sv
// Coded-exposure mask pattern store: the host loads row words into block RAM,
// and they are replayed one row per STREAM cycle, advancing one pattern per burst.
module mask_pattern_feeder #(
  parameter int C_MASK_DES_L = 18,
  parameter int C_NUM_ROWS   = 160,
  parameter int C_MAX_PATT   = 8,
  parameter int C_ADDR_W     = 11
) (
  input  logic                    CLKMPRE,
  input  logic                    RESET_B,
  input  logic                    LOAD_START,
  input  logic [15:0]             NUM_STORED,
  input  logic                    WR_VALID,
  input  logic [C_MASK_DES_L-1:0] WR_DATA,
  output logic                    WR_READY,
  output logic                    LOAD_DONE,
  input  logic                    STREAM,
  input  logic                    FRAME_RST,
  output logic [C_MASK_DES_L-1:0] MASK_DATA,
  output logic                    MASK_VALID,
  output logic [15:0]             PAT_IDX,
  output logic [C_ADDR_W-1:0]     ROW_IDX,
  output logic                    UNDERRUN,
  output logic                    ROW_OVR
);

  localparam int C_DEPTH = C_MAX_PATT * C_NUM_ROWS;
  localparam logic [C_ADDR_W-1:0] ROWS_A = C_ADDR_W'(C_NUM_ROWS);

  typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_READY} state_t;

  state_t                  state_reg, state_next;
  logic [C_ADDR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [C_ADDR_W-1:0]     last_addr_reg, last_addr_next;
  logic [15:0]             nstore_reg, nstore_next;
  logic [15:0]             pat_idx_reg, pat_idx_next;
  logic [C_ADDR_W-1:0]     row_idx_reg, row_idx_next;
  logic [C_ADDR_W-1:0]     base_reg, base_next;
  logic                    underrun_reg, underrun_next;
  logic                    row_ovr_reg, row_ovr_next;
  logic                    mask_valid_reg;
  logic                    stream_q_reg;
  logic [C_MASK_DES_L-1:0] rd_data_reg;
  logic [C_MASK_DES_L-1:0] mem [0:C_DEPTH-1];

  logic [15:0]         nstore_clamp;
  logic                wr_en, rd_en, burst_end;
  logic [C_ADDR_W-1:0] rd_addr;

  always_comb begin
    nstore_clamp = NUM_STORED;
    if (NUM_STORED == 16'd0)
      nstore_clamp = 16'd1;
    else if (NUM_STORED > 16'(C_MAX_PATT))
      nstore_clamp = 16'(C_MAX_PATT);
  end

  // LOAD_START pre-empts both the host write port and the replay port
  assign wr_en     = (state_reg == ST_LOAD) && WR_VALID && !LOAD_START;
  assign rd_en     = (state_reg == ST_READY) && STREAM && !LOAD_START && (row_idx_reg < ROWS_A);
  assign rd_addr   = base_reg + row_idx_reg;
  assign burst_end = stream_q_reg && !STREAM;

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    last_addr_next = last_addr_reg;
    nstore_next    = nstore_reg;
    pat_idx_next   = pat_idx_reg;
    row_idx_next   = row_idx_reg;
    base_next      = base_reg;
    underrun_next  = underrun_reg;
    row_ovr_next   = row_ovr_reg;

    if (LOAD_START) begin
      state_next     = ST_LOAD;
      wr_ptr_next    = '0;
      nstore_next    = nstore_clamp;
      last_addr_next = C_ADDR_W'(32'(nstore_clamp) * 32'(C_NUM_ROWS) - 32'd1);
      pat_idx_next   = '0;
      row_idx_next   = '0;
      base_next      = '0;
      underrun_next  = 1'b0;
      row_ovr_next   = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
        if (wr_ptr_reg == last_addr_reg)
          state_next = ST_READY;
      end

      if (STREAM && (state_reg != ST_READY))
        underrun_next = 1'b1;
      if (STREAM && (state_reg == ST_READY) && (row_idx_reg == ROWS_A))
        row_ovr_next = 1'b1;

      if (FRAME_RST) begin
        pat_idx_next = '0;
        row_idx_next = '0;
        base_next    = '0;
      end else if ((state_reg == ST_READY) && burst_end) begin
        row_idx_next = '0;
        if (pat_idx_reg == nstore_reg - 16'd1) begin
          pat_idx_next = '0;
          base_next    = '0;
        end else begin
          pat_idx_next = pat_idx_reg + 16'd1;
          base_next    = base_reg + ROWS_A;
        end
      end else if (rd_en) begin
        row_idx_next = row_idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge CLKMPRE or negedge RESET_B) begin
    if (!RESET_B) begin
      state_reg      <= ST_EMPTY;
      wr_ptr_reg     <= '0;
      last_addr_reg  <= ROWS_A - 1'b1;
      nstore_reg     <= 16'd1;
      pat_idx_reg    <= '0;
      row_idx_reg    <= '0;
      base_reg       <= '0;
      underrun_reg   <= 1'b0;
      row_ovr_reg    <= 1'b0;
      mask_valid_reg <= 1'b0;
      stream_q_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      last_addr_reg  <= last_addr_next;
      nstore_reg     <= nstore_next;
      pat_idx_reg    <= pat_idx_next;
      row_idx_reg    <= row_idx_next;
      base_reg       <= base_next;
      underrun_reg   <= underrun_next;
      row_ovr_reg    <= row_ovr_next;
      mask_valid_reg <= rd_en;
      stream_q_reg   <= STREAM;
    end
  end

  // Pattern RAM has no reset so it maps onto block RAM; output gating hides stale data
  always_ff @(posedge CLKMPRE) begin
    if (wr_en)
      mem[wr_ptr_reg] <= WR_DATA;
    if (rd_en)
      rd_data_reg <= mem[rd_addr];
  end

  assign WR_READY   = (state_reg == ST_LOAD);
  assign LOAD_DONE  = (state_reg == ST_READY);
  assign MASK_VALID = mask_valid_reg;
  assign MASK_DATA  = mask_valid_reg ? rd_data_reg : '0;
  assign PAT_IDX    = pat_idx_reg;
  assign ROW_IDX    = row_idx_reg;
  assign UNDERRUN   = underrun_reg;
  assign ROW_OVR    = row_ovr_reg;

endmodule

// File: tb/tb_mask_pattern_feeder.sv
// Randomized bench for mask_pattern_feeder: a pattern-level model (flat word array,
// current pattern number, sticky flags) predicts every replayed word and status output.
module tb_mask_pattern_feeder;
  localparam int W = 18;
  localparam int R = 160;
  localparam int P = 8;
  localparam int A = 11;

  logic          CLKMPRE = 1'b0;
  logic          RESET_B = 1'b0;
  logic          LOAD_START = 1'b0;
  logic [15:0]   NUM_STORED = '0;
  logic          WR_VALID = 1'b0;
  logic [W-1:0]  WR_DATA = '0;
  logic          WR_READY, LOAD_DONE;
  logic          STREAM = 1'b0;
  logic          FRAME_RST = 1'b0;
  logic [W-1:0]  MASK_DATA;
  logic          MASK_VALID;
  logic [15:0]   PAT_IDX;
  logic [A-1:0]  ROW_IDX;
  logic          UNDERRUN, ROW_OVR;

  mask_pattern_feeder #(.C_MASK_DES_L(W), .C_NUM_ROWS(R), .C_MAX_PATT(P), .C_ADDR_W(A)) dut (
    .CLKMPRE(CLKMPRE), .RESET_B(RESET_B), .LOAD_START(LOAD_START), .NUM_STORED(NUM_STORED),
    .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY), .LOAD_DONE(LOAD_DONE),
    .STREAM(STREAM), .FRAME_RST(FRAME_RST), .MASK_DATA(MASK_DATA), .MASK_VALID(MASK_VALID),
    .PAT_IDX(PAT_IDX), .ROW_IDX(ROW_IDX), .UNDERRUN(UNDERRUN), .ROW_OVR(ROW_OVR)
  );

  always #5 CLKMPRE = ~CLKMPRE;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [W-1:0] m_mem [0:P*R-1];
  int m_nstore = 1;
  int m_pat = 0;
  bit m_ovr = 0;
  bit m_unr = 0;

  task automatic tick();
    @(posedge CLKMPRE);
    #1;
  endtask

  task automatic test_reset();
    RESET_B = 1'b0;
    tick(); tick();
    RESET_B = 1'b1;
    tick();
    vectors++; if (WR_READY !== 1'b0) begin miscompares++; $display("FAIL reset_wr_ready got %0b want 0", WR_READY); end
    vectors++; if (LOAD_DONE !== 1'b0) begin miscompares++; $display("FAIL reset_load_done got %0b want 0", LOAD_DONE); end
    vectors++; if (MASK_VALID !== 1'b0 || MASK_DATA !== '0) begin miscompares++; $display("FAIL reset_mask got v=%0b d=%0h want 0/0", MASK_VALID, MASK_DATA); end
    vectors++; if (PAT_IDX !== 16'd0 || ROW_IDX !== '0) begin miscompares++; $display("FAIL reset_idx got pat=%0d row=%0d want 0/0", PAT_IDX, ROW_IDX); end
    vectors++; if (UNDERRUN !== 1'b0 || ROW_OVR !== 1'b0) begin miscompares++; $display("FAIL reset_flags got unr=%0b ovr=%0b want 0/0", UNDERRUN, ROW_OVR); end
    $display("reset: outputs checked");
  endtask

  task automatic test_underrun(input int len);
    for (int k = 0; k < len; k++) begin
      STREAM = 1'b1;
      tick();
      m_unr = 1;
      vectors++; if (MASK_VALID !== 1'b0 || MASK_DATA !== '0) begin miscompares++; $display("FAIL underrun_mask got v=%0b d=%0h want 0/0", MASK_VALID, MASK_DATA); end
      vectors++; if (UNDERRUN !== m_unr) begin miscompares++; $display("FAIL underrun_flag got %0b want %0b", UNDERRUN, m_unr); end
    end
    STREAM = 1'b0;
    tick();
    $display("underrun: %0d stream cycles without a resident set", len);
  endtask

  task automatic test_load(input int num, input bit addr_data);
    int n;
    int nw;
    n  = (num == 0) ? 1 : ((num > P) ? P : num);
    nw = n * R;
    NUM_STORED = 16'(num);
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
    m_nstore = n; m_pat = 0; m_ovr = 0; m_unr = 0;
    vectors++; if (WR_READY !== 1'b1 || LOAD_DONE !== 1'b0) begin miscompares++; $display("FAIL load_start got rdy=%0b done=%0b want 1/0", WR_READY, LOAD_DONE); end
    vectors++; if (UNDERRUN !== 1'b0 || ROW_OVR !== 1'b0) begin miscompares++; $display("FAIL load_clr_flags got unr=%0b ovr=%0b want 0/0", UNDERRUN, ROW_OVR); end
    vectors++; if (PAT_IDX !== 16'd0 || ROW_IDX !== '0) begin miscompares++; $display("FAIL load_clr_idx got pat=%0d row=%0d want 0/0", PAT_IDX, ROW_IDX); end
    for (int i = 0; i < nw; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        WR_VALID = 1'b0;
        WR_DATA  = W'($urandom);
        tick();
      end
      WR_VALID = 1'b1;
      WR_DATA  = addr_data ? W'(i) : W'($urandom);
      m_mem[i] = WR_DATA;
      tick();
      if (i == nw - 2) begin
        vectors++; if (LOAD_DONE !== 1'b0 || WR_READY !== 1'b1) begin miscompares++; $display("FAIL load_early_done got done=%0b rdy=%0b want 0/1", LOAD_DONE, WR_READY); end
      end
    end
    vectors++; if (LOAD_DONE !== 1'b1 || WR_READY !== 1'b0) begin miscompares++; $display("FAIL load_done got done=%0b rdy=%0b want 1/0", LOAD_DONE, WR_READY); end
    // a write attempted once the set is resident must be ignored
    WR_DATA = ~m_mem[0];
    tick();
    WR_VALID = 1'b0;
    $display("load: NUM_STORED=%0d -> %0d patterns, %0d words", num, n, nw);
  endtask

  task automatic test_burst(input int len, input bit frst);
    logic [W-1:0] ed;
    logic         ev;
    int           er;
    int           start_pat;
    start_pat = m_pat;
    for (int k = 0; k < len; k++) begin
      STREAM = 1'b1;
      tick();
      ev = (k < R);
      ed = ev ? m_mem[m_pat * R + k] : '0;
      er = ev ? k + 1 : R;
      if (!ev) m_ovr = 1;
      vectors++; if (MASK_VALID !== ev || MASK_DATA !== ed) begin miscompares++; $display("FAIL burst_data pat=%0d row=%0d got v=%0b d=%0h want v=%0b d=%0h", m_pat, k, MASK_VALID, MASK_DATA, ev, ed); end
      vectors++; if (ROW_IDX !== A'(er) || PAT_IDX !== 16'(m_pat)) begin miscompares++; $display("FAIL burst_idx got pat=%0d row=%0d want pat=%0d row=%0d", PAT_IDX, ROW_IDX, m_pat, er); end
      vectors++; if (ROW_OVR !== m_ovr) begin miscompares++; $display("FAIL burst_row_ovr row=%0d got %0b want %0b", k, ROW_OVR, m_ovr); end
    end
    STREAM = 1'b0;
    FRAME_RST = frst;
    tick();
    FRAME_RST = 1'b0;
    m_pat = frst ? 0 : (m_pat + 1) % m_nstore;
    vectors++; if (MASK_VALID !== 1'b0 || MASK_DATA !== '0) begin miscompares++; $display("FAIL burst_tail got v=%0b d=%0h want 0/0", MASK_VALID, MASK_DATA); end
    vectors++; if (PAT_IDX !== 16'(m_pat) || ROW_IDX !== '0) begin miscompares++; $display("FAIL burst_end_idx got pat=%0d row=%0d want pat=%0d row=0", PAT_IDX, ROW_IDX, m_pat); end
    vectors++; if (UNDERRUN !== m_unr) begin miscompares++; $display("FAIL burst_underrun got %0b want %0b", UNDERRUN, m_unr); end
    $display("burst: pat=%0d len=%0d frame_rst=%0b next_pat=%0d", start_pat, len, frst, m_pat);
  endtask

  task automatic test_reset_midburst();
    for (int k = 0; k < 20; k++) begin
      STREAM = 1'b1;
      tick();
    end
    #3;
    RESET_B = 1'b0;
    #1;
    vectors++; if (MASK_VALID !== 1'b0 || MASK_DATA !== '0) begin miscompares++; $display("FAIL async_reset_mask got v=%0b d=%0h want 0/0", MASK_VALID, MASK_DATA); end
    vectors++; if (LOAD_DONE !== 1'b0 || PAT_IDX !== 16'd0 || ROW_IDX !== '0) begin miscompares++; $display("FAIL async_reset_state got done=%0b pat=%0d row=%0d want 0/0/0", LOAD_DONE, PAT_IDX, ROW_IDX); end
    STREAM = 1'b0;
    tick();
    RESET_B = 1'b1;
    tick();
    m_pat = 0; m_ovr = 0; m_unr = 0;
    $display("async reset: applied mid-burst");
  endtask

  initial begin
    test_reset();
    test_underrun(3);

    // two patterns holding their own addresses: replay and wrap
    test_load(2, 1'b1);
    test_burst(R, 1'b0);
    test_burst(R, 1'b0);
    test_burst(R, 1'b0);
    test_burst(R + 2, 1'b0);
    test_burst(R, 1'b0);

    // random data, random burst lengths, frame sync coinciding with burst end
    test_load(3, 1'b0);
    test_burst(int'($urandom_range(1, R)), 1'b0);
    test_burst(int'($urandom_range(1, R)), 1'b1);
    for (int b = 0; b < 6; b++)
      test_burst(int'($urandom_range(1, R)), ($urandom_range(0, 3) == 0));

    // oversize request clamps to full capacity
    test_load(20, 1'b0);
    for (int b = 0; b < P + 1; b++)
      test_burst(int'($urandom_range(1, 8)), 1'b0);

    test_reset_midburst();
    test_load(0, 1'b0);
    test_burst(R, 1'b0);
    test_burst(R, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
